spike_count_decoder: RTL and testbench

Rate-code readout that sits on the output end of the two-layer spiking network and consumes its output_spikes bus.
- Counts spikes per output neuron over a programmable window of enabled samples.
- Runs a sequential argmax over the counts and reports the winning class index with a one-cycle valid pulse.
- Feeds keyword-class decisions to downstream control logic.

---
 rtl/spike_count_decoder_pkg.sv | 21 ++
 rtl/spike_count_decoder_counter.sv | 26 ++
 rtl/spike_count_decoder.sv | 123 ++++++++++++
 tb/tb_spike_count_decoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/spike_count_decoder_pkg.sv
// Shared sizing, state encoding and saturating-increment helper for the spike-count readout.
// Pure declarations; no timing or flow-control behaviour of its own.
package snn_decoder_pkg;

  localparam int N    = 8;
  localparam int CW   = 8;
  localparam int LW   = 16;
  localparam int IDXW = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

endpackage

// File: rtl/spike_count_decoder_counter.sv
// Per-neuron saturating spike counter: one-cycle update, clear wins over count.
// No backpressure; counts whenever i_en and i_inc are both high.
module spike_counter
  import snn_decoder_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && i_inc) begin
      r_cnt <= sat_inc(r_cnt);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/spike_count_decoder.sv
// Rate-code readout: counts output spikes over a window, then a sequential argmax picks the class.
// class_valid pulses N+1 cycles after the final-sample edge; start is dropped while busy.
module spike_count_decoder
  import snn_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic [LW-1:0]     window_len,
  input  logic [N-1:0]      spikes_in,
  output logic              busy,
  output logic              class_valid,
  output logic [IDXW-1:0]   class_idx,
  output logic [CW-1:0]     class_count,
  output logic              no_spike,
  output logic [N*CW-1:0]   spike_counts
);

  localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] S_COUNT = 2'(ST_COUNT);
  localparam logic [1:0] S_SCAN  = 2'(ST_SCAN);
  localparam logic [1:0] S_DONE  = 2'(ST_DONE);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [LW-1:0]   r_len;
  logic [LW-1:0]   r_sample;
  logic [IDXW-1:0] r_scan_k;
  logic [IDXW-1:0] r_best_idx;
  logic [CW-1:0]   r_best_cnt;
  logic            r_busy;
  logic            r_class_valid;
  logic [IDXW-1:0] r_class_idx;
  logic [CW-1:0]   r_class_count;
  logic            r_no_spike;

  logic            w_start_acc;
  logic            w_count_en;
  logic            w_last_sample;
  logic [CW-1:0]   w_scan_cnt;
  logic [CW-1:0]   w_cnt [N];

  assign w_start_acc   = (r_state == S_IDLE) && start;
  assign w_count_en    = (r_state == S_COUNT) && enable;
  assign w_last_sample = w_count_en && (r_sample == r_len - LW'(1));
  assign w_scan_cnt    = w_cnt[r_scan_k];

  for (genvar gi = 0; gi < N; gi++) begin : g_cnt
    spike_counter u_cnt (
      .i_clk (clk),
      .i_rst (reset),
      .i_clr (w_start_acc),
      .i_en  (w_count_en),
      .i_inc (spikes_in[gi]),
      .o_cnt (w_cnt[gi])
    );
    assign spike_counts[gi*CW +: CW] = w_cnt[gi];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (window_len == '0) ? S_SCAN : S_COUNT;
      S_COUNT: if (w_last_sample) w_state_nxt = S_SCAN;
      S_SCAN:  if (r_scan_k == IDXW'(N-1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_len         <= '0;
      r_sample      <= '0;
      r_scan_k      <= '0;
      r_best_idx    <= '0;
      r_best_cnt    <= '0;
      r_busy        <= 1'b0;
      r_class_valid <= 1'b0;
      r_class_idx   <= '0;
      r_class_count <= '0;
      r_no_spike    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_class_valid <= 1'b0;

      if (w_start_acc) begin
        r_len    <= window_len;
        r_sample <= '0;
      end else if (w_count_en) begin
        r_sample <= r_sample + LW'(1);
      end

      // Neuron 0 seeds the best; strict > keeps the lowest index on ties.
      if (r_state == S_SCAN) begin
        r_scan_k <= r_scan_k + IDXW'(1);
        if ((r_scan_k == '0) || (w_scan_cnt > r_best_cnt)) begin
          r_best_idx <= r_scan_k;
          r_best_cnt <= w_scan_cnt;
        end
      end else begin
        r_scan_k <= '0;
      end

      if (r_state == S_DONE) begin
        r_class_idx   <= r_best_idx;
        r_class_count <= r_best_cnt;
        r_no_spike    <= (r_best_cnt == '0);
        r_class_valid <= 1'b1;
      end
    end
  end

  assign busy        = r_busy;
  assign class_valid = r_class_valid;
  assign class_idx   = r_class_idx;
  assign class_count = r_class_count;
  assign no_spike    = r_no_spike;

endmodule

// File: tb/tb_spike_count_decoder.sv
// Self-checking bench for spike_count_decoder: directed vector table plus randomized windows
// checked against a count-and-argmax model built from the window rules.
module tb_spike_count_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        start;
  logic [15:0] window_len;
  logic [7:0]  spikes_in;
  logic        busy;
  logic        class_valid;
  logic [2:0]  class_idx;
  logic [7:0]  class_count;
  logic        no_spike;
  logic [63:0] spike_counts;

  int n_tests = 0;
  int n_fail  = 0;

  spike_count_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .start        (start),
    .window_len   (window_len),
    .spikes_in    (spikes_in),
    .busy         (busy),
    .class_valid  (class_valid),
    .class_idx    (class_idx),
    .class_count  (class_count),
    .no_spike     (no_spike),
    .spike_counts (spike_counts)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // en_mode: 0 always, 1 toggle, 2 random. spk_mode: 0 constant, 1 tie pattern, 2 random.
  task automatic run_window(input logic [15:0] len, input int en_mode, input int spk_mode,
                            input logic [7:0] spk_k, input logic junk_start,
                            output logic [2:0] o_idx, output logic [7:0] o_cnt, output logic o_ns);
    int          cnt_m [8];
    int          sat   [8];
    int          samples;
    int          cyc;
    int          best;
    int          lat;
    logic        en;
    logic [7:0]  spk;
    logic [63:0] exp_sc;
    logic        busy_after;

    for (int i = 0; i < 8; i++) cnt_m[i] = 0;
    @(negedge clk);
    start      = 1'b1;
    window_len = len;
    enable     = 1'b1;
    spikes_in  = 8'hFF;
    @(negedge clk);
    start      = 1'b0;
    window_len = 16'($urandom);

    samples = 0;
    cyc     = 0;
    while (samples < int'(len)) begin
      case (en_mode)
        0:       en = 1'b1;
        1:       en = (cyc % 2) == 0;
        default: en = ($urandom % 4) != 0;
      endcase
      case (spk_mode)
        0:       spk = spk_k;
        1:       spk = ((samples < 4) ? 8'h02 : 8'h00) | ((samples >= 4) ? 8'h20 : 8'h00)
                     | ((samples < 3) ? 8'h08 : 8'h00);
        default: spk = 8'($urandom) & 8'($urandom);
      endcase
      enable    = en;
      spikes_in = spk;
      if (en) begin
        for (int i = 0; i < 8; i++) if (spk[i]) cnt_m[i]++;
        samples++;
      end
      cyc++;
      @(negedge clk);
    end

    // Window closed on the last edge; scan inputs are junk and start pulses must be ignored.
    lat        = 0;
    busy_after = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      enable    = 1'($urandom);
      spikes_in = 8'($urandom);
      start     = junk_start ? 1'($urandom) : 1'b0;
      @(negedge clk);
      if (k == 1) busy_after = busy;
      if (class_valid) lat = k;
    end
    start = 1'b0;

    best = 0;
    for (int i = 0; i < 8; i++) begin
      sat[i] = (cnt_m[i] > 255) ? 255 : cnt_m[i];
      exp_sc[i*8 +: 8] = 8'(sat[i]);
    end
    for (int i = 1; i < 8; i++) if (sat[i] > sat[best]) best = i;

    check("busy_in_scan", 64'(busy_after), 64'(1));
    check("valid_latency", 64'(lat), 64'(9));
    check("class_idx_model", 64'(class_idx), 64'(best));
    check("class_count_model", 64'(class_count), 64'(sat[best]));
    check("no_spike_model", 64'(no_spike), 64'(sat[best] == 0));
    check("spike_counts_model", spike_counts, exp_sc);
    o_idx = class_idx;
    o_cnt = class_count;
    o_ns  = no_spike;
    @(negedge clk);
    check("valid_one_cycle", 64'(class_valid), 64'(0));
    check("idle_after_done", 64'(busy), 64'(0));
  endtask

  typedef struct {
    logic [15:0] len;
    int          en_mode;
    int          spk_mode;
    logic [7:0]  spk_k;
    logic        junk_start;
    logic [2:0]  e_idx;
    logic [7:0]  e_cnt;
    logic        e_ns;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [2:0]  r_idx;
    logic [7:0]  r_cnt;
    logic        r_ns;
    logic        seen_valid;

    vecs[0] = '{16'd10,    0, 0, 8'h04, 1'b0, 3'd2, 8'd10,  1'b0};
    vecs[1] = '{16'd8,     0, 1, 8'h00, 1'b1, 3'd1, 8'd4,   1'b0};
    vecs[2] = '{16'd300,   0, 0, 8'h80, 1'b0, 3'd7, 8'd255, 1'b0};
    vecs[3] = '{16'd4,     1, 0, 8'hFF, 1'b0, 3'd0, 8'd4,   1'b0};
    vecs[4] = '{16'd0,     0, 0, 8'h00, 1'b0, 3'd0, 8'd0,   1'b1};
    vecs[5] = '{16'hFFFF,  0, 0, 8'h01, 1'b1, 3'd0, 8'd255, 1'b0};

    reset      = 1'b1;
    enable     = 1'b0;
    start      = 1'b0;
    window_len = '0;
    spikes_in  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_valid", 64'(class_valid), 64'(0));
    check("reset_idx", 64'(class_idx), 64'(0));
    check("reset_count", 64'(class_count), 64'(0));
    check("reset_no_spike", 64'(no_spike), 64'(0));
    check("reset_counts", spike_counts, 64'(0));
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_window(vecs[v].len, vecs[v].en_mode, vecs[v].spk_mode, vecs[v].spk_k,
                 vecs[v].junk_start, r_idx, r_cnt, r_ns);
      check($sformatf("vec%0d_idx", v), 64'(r_idx), 64'(vecs[v].e_idx));
      check($sformatf("vec%0d_count", v), 64'(r_cnt), 64'(vecs[v].e_cnt));
      check($sformatf("vec%0d_no_spike", v), 64'(r_ns), 64'(vecs[v].e_ns));
    end

    // Reset in the middle of counting: everything clears and no result ever appears.
    @(negedge clk);
    start      = 1'b1;
    window_len = 16'd10;
    @(negedge clk);
    start     = 1'b0;
    enable    = 1'b1;
    spikes_in = 8'hFF;
    repeat (3) @(negedge clk);
    check("midcount_counts", spike_counts[7:0], 64'(3));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", 64'(busy), 64'(0));
    check("midreset_counts", spike_counts, 64'(0));
    check("midreset_valid", 64'(class_valid), 64'(0));
    check("midreset_idx", 64'(class_idx), 64'(0));
    seen_valid = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen_valid |= class_valid;
    end
    check("midreset_no_result", 64'(seen_valid), 64'(0));
    check("midreset_stays_idle", 64'(busy), 64'(0));

    for (int r = 0; r < 20; r++) begin
      logic [15:0] len;
      len = (($urandom % 8) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      run_window(len, 2, 2, 8'h00, 1'($urandom), r_idx, r_cnt, r_ns);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
